// File: rtl/admo_ex_stage.sv
// admo_ex_stage: execute stage - ALU operand/operator select, branch resolve, EX/MEM register, fetch redirect.
// Define ADMO_EX_FWD_EN to forward the EX/MEM result into rs1/rs2 and stall on load-use hazards.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef ALU_ADD
`define ALU_ADD 4'd0
`endif
`ifndef ALU_SUB
`define ALU_SUB 4'd1
`endif
`ifndef ALU_LTS
`define ALU_LTS 4'd2
`endif
`ifndef ALU_LTU
`define ALU_LTU 4'd3
`endif

module admo_ex_stage #(
    parameter int unsigned DATA_WIDTH = `DATA_WIDTH,
    parameter int unsigned REG_AW     = 5
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  id_valid_i,
    output logic                  id_ready_o,
    input  logic [DATA_WIDTH-1:0] id_pc_i,
    input  logic [DATA_WIDTH-1:0] id_rs1_data_i,
    input  logic [DATA_WIDTH-1:0] id_rs2_data_i,
    input  logic [REG_AW-1:0]     id_rs1_addr_i,
    input  logic [REG_AW-1:0]     id_rs2_addr_i,
    input  logic [DATA_WIDTH-1:0] id_imm_i,
    input  logic [1:0]            id_op_a_sel_i,
    input  logic                  id_op_b_sel_i,
    input  logic [3:0]            id_alu_op_i,
    input  logic [2:0]            id_br_type_i,
    input  logic                  id_jalr_i,
    input  logic [REG_AW-1:0]     id_rd_addr_i,
    input  logic                  id_rd_we_i,
    input  logic [3:0]            id_mem_ctrl_i,
    output logic [DATA_WIDTH-1:0] alu_operand_a_o,
    output logic [DATA_WIDTH-1:0] alu_operand_b_o,
    output logic [3:0]            alu_operator_o,
    input  logic [DATA_WIDTH-1:0] alu_result_i,
    output logic                  ex_valid_o,
    input  logic                  ex_ready_i,
    output logic [DATA_WIDTH-1:0] ex_result_o,
    output logic [DATA_WIDTH-1:0] ex_store_data_o,
    output logic [REG_AW-1:0]     ex_rd_addr_o,
    output logic                  ex_rd_we_o,
    output logic [3:0]            ex_mem_ctrl_o,
    output logic                  redirect_valid_o,
    output logic [DATA_WIDTH-1:0] redirect_pc_o
);

    localparam logic [2:0] BR_NONE = 3'd0;
    localparam logic [2:0] BR_BEQ  = 3'd1;
    localparam logic [2:0] BR_BNE  = 3'd2;
    localparam logic [2:0] BR_BLT  = 3'd3;
    localparam logic [2:0] BR_BGE  = 3'd4;
    localparam logic [2:0] BR_BLTU = 3'd5;
    localparam logic [2:0] BR_BGEU = 3'd6;
    localparam logic [2:0] BR_JUMP = 3'd7;

    logic [DATA_WIDTH-1:0] rs1;
    logic [DATA_WIDTH-1:0] rs2;
    logic                  load_stall;
    logic                  accept;
    logic                  taken;
    logic                  is_branch;
    logic [DATA_WIDTH-1:0] tgt_sum;
    logic [DATA_WIDTH-1:0] target;
    logic [DATA_WIDTH-1:0] result;

`ifdef ADMO_EX_FWD_EN
    logic hit1;
    logic hit2;

    // Each source independently picks up the in-flight EX/MEM result.
    always_comb begin
        hit1 = ex_valid_o & ex_rd_we_o & (ex_rd_addr_o != '0) & (ex_rd_addr_o == id_rs1_addr_i);
        hit2 = ex_valid_o & ex_rd_we_o & (ex_rd_addr_o != '0) & (ex_rd_addr_o == id_rs2_addr_i);
        rs1 = hit1 ? ex_result_o : id_rs1_data_i;
        rs2 = hit2 ? ex_result_o : id_rs2_data_i;
        load_stall = (hit1 | hit2) & ex_mem_ctrl_o[3];
    end
`else
    logic unused_fwd;

    assign rs1        = id_rs1_data_i;
    assign rs2        = id_rs2_data_i;
    assign load_stall = 1'b0;
    assign unused_fwd = ^{id_rs1_addr_i, id_rs2_addr_i};
`endif

    assign is_branch  = (id_br_type_i != BR_NONE) & (id_br_type_i != BR_JUMP);
    assign id_ready_o = (~ex_valid_o | ex_ready_i) & ~redirect_valid_o & ~load_stall;
    assign accept     = id_valid_i & id_ready_o;

    // Conditional branches take over the ALU for their compare.
    always_comb begin
        alu_operand_a_o = rs1;
        alu_operand_b_o = rs2;
        alu_operator_o  = id_alu_op_i;
        case (id_br_type_i)
            BR_BEQ, BR_BNE:   alu_operator_o = `ALU_SUB;
            BR_BLT, BR_BGE:   alu_operator_o = `ALU_LTS;
            BR_BLTU, BR_BGEU: alu_operator_o = `ALU_LTU;
            default: begin
                case (id_op_a_sel_i)
                    2'b00:   alu_operand_a_o = rs1;
                    2'b01:   alu_operand_a_o = id_pc_i;
                    default: alu_operand_a_o = '0;
                endcase
                alu_operand_b_o = id_op_b_sel_i ? id_imm_i : rs2;
            end
        endcase
    end

    always_comb begin
        case (id_br_type_i)
            BR_BEQ:           taken = (alu_result_i == '0);
            BR_BNE:           taken = (alu_result_i != '0);
            BR_BLT, BR_BLTU:  taken = alu_result_i[0];
            BR_BGE, BR_BGEU:  taken = ~alu_result_i[0];
            BR_JUMP:          taken = 1'b1;
            default:          taken = 1'b0;
        endcase
    end

    assign tgt_sum = (id_jalr_i ? rs1 : id_pc_i) + id_imm_i;
    assign target  = id_jalr_i ? {tgt_sum[DATA_WIDTH-1:1], 1'b0} : tgt_sum;

    // Jumps write the link address; conditional branches write nothing.
    always_comb begin
        result = alu_result_i;
        if (id_br_type_i == BR_JUMP) begin
            result = id_pc_i + DATA_WIDTH'(4);
        end else if (is_branch) begin
            result = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ex_valid_o       <= 1'b0;
            ex_result_o      <= '0;
            ex_store_data_o  <= '0;
            ex_rd_addr_o     <= '0;
            ex_rd_we_o       <= 1'b0;
            ex_mem_ctrl_o    <= '0;
            redirect_valid_o <= 1'b0;
            redirect_pc_o    <= '0;
        end else begin
            redirect_valid_o <= accept & taken;
            if (accept & taken) begin
                redirect_pc_o <= target;
            end
            if (accept) begin
                ex_valid_o      <= 1'b1;
                ex_result_o     <= result;
                ex_store_data_o <= rs2;
                ex_rd_addr_o    <= id_rd_addr_i;
                ex_rd_we_o      <= id_rd_we_i & ~is_branch;
                ex_mem_ctrl_o   <= id_mem_ctrl_i;
            end else if (ex_ready_i) begin
                ex_valid_o <= 1'b0;
            end
        end
    end

endmodule
